mipi_packet_decoder: RTL and testbench
======================================

MIPI_PACKET_DECODER -- requirements
Module: mipi_packet_decoder

Interface
REQ-001 The block SHALL have parameter ECC_CHECK, default 1, meaning 1 = ECC mismatch aborts the burst and 0 = ECC is still flagged but the packet is parsed anyway.
REQ-002 The block SHALL have port clk  input  1  single clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port din  input  8  aligned byte from the upstream byte aligner, LSB = first bit on the wire.
REQ-005 The block SHALL have port din_valid  input  1  aligner lock; high for every byte of one HS burst, low otherwise.
REQ-006 The block SHALL have port hdr_valid  output  1  one-cycle pulse when a 4-byte packet header has been parsed.
REQ-007 The block SHALL have port vc  output  2  virtual channel, DI[7:6]; held until the next hdr_valid.
REQ-008 The block SHALL have port dt  output  6  data type, DI[5:0]; held until the next hdr_valid.
REQ-009 The block SHALL have port wc  output  16  {header byte 3, header byte 2}, i.e. word count or short-packet data; held until the next hdr_valid.
REQ-010 The block SHALL have port is_long  output  1  packet classification; held until the next hdr_valid.
REQ-011 The block SHALL have port ecc_err  output  1  qualified by hdr_valid.
REQ-012 The block SHALL have port pl_data  output  8  long-packet payload byte.
REQ-013 The block SHALL have port pl_valid  output  1  payload byte strobe.
REQ-014 The block SHALL have port pkt_end  output  1  one-cycle pulse at the end of any packet, short or long.
REQ-015 The block SHALL have port crc_err  output  1  qualified by pkt_end; always 0 for short packets.
REQ-016 The block SHALL have port trunc  output  1  one-cycle pulse when din_valid falls inside a header, payload or checksum.

Function
REQ-017 The block SHALL implement the states IDLE, HDR, PAYLOAD, CRC and DRAIN.
REQ-018 IDLE: go to HDR with byte index 0 on the first cycle din_valid=1, capturing that byte as DI.
REQ-019 HDR: capture 4 bytes in order DI, WC_L, WC_H, ECC.
REQ-020 On the 4th header byte the block SHALL raise hdr_valid on the next cycle, so outputs become valid 1 cycle after the ECC byte is sampled.
REQ-021 The block SHALL drive ecc_err=1 when the received ECC[5:0] differs from the MIPI DSI 6-bit Hamming ECC over {WC_H, WC_L, DI}; ECC bits 7:6 SHALL be ignored, and the block SHALL NOT correct errors.
REQ-022 is_long SHALL be 1 if and only if dt[3:0] is 4'h9, 4'hC, 4'hD or 4'hE.
REQ-023 After the header, the block SHALL go to DRAIN if ecc_err=1 and ECC_CHECK=1.
REQ-024 Otherwise, for a short packet, the block SHALL pulse pkt_end together with hdr_valid, then go to DRAIN if dt==6'h08 (EoTp) or else return to HDR for the next packet in the same burst.
REQ-025 Otherwise, for a long packet with wc>0, the block SHALL go to PAYLOAD; with wc==0 it SHALL go directly to CRC.
REQ-026 PAYLOAD: each sampled byte SHALL appear on pl_data with pl_valid=1 one cycle later, for exactly wc bytes; a 16-bit down-counter loaded with wc SHALL handle the full range 1..65535 without wrap.
REQ-027 CRC: the block SHALL run CRC-16, reflected poly 0x8408, init 0xFFFF, no final XOR, over the payload bytes.
REQ-028 The block SHALL receive 2 checksum bytes, LSB first, and compare them against the computed value; for wc==0 the expected value SHALL be 0xFFFF.
REQ-029 The block SHALL pulse pkt_end one cycle after the 2nd checksum byte, with crc_err=1 on mismatch, then return to HDR.
REQ-030 DRAIN: ignore din while din_valid=1, and return to IDLE when din_valid=0.
REQ-031 If din_valid falls in HDR (index>0), PAYLOAD or CRC, the block SHALL pulse trunc, SHALL NOT pulse pkt_end, and SHALL go to IDLE.
REQ-032 din_valid=0 in HDR at index 0 (a clean gap between packets) SHALL return the block to IDLE with no pulse.
REQ-033 hdr_valid, pkt_end and trunc SHALL never be high for more than 1 cycle.
REQ-034 pl_valid SHALL never overlap trunc.

Reset
REQ-035 With rst=1 at a clock edge, on the next cycle state=IDLE and every output SHALL be 0, including vc/dt/wc/is_long and pl_data.
REQ-036 rst SHALL have priority over din_valid.
REQ-037 A reset mid-packet SHALL discard all partial state and SHALL produce no pkt_end or trunc.

Verification
REQ-038 Short packet: burst 05 11 00 36 -> hdr_valid with dt=0x05, vc=0, wc=0x0011, is_long=0, ecc_err=0, and pkt_end in the same cycle with crc_err=0.
REQ-039 Two packets in one burst: 05 11 00 36, 05 29 00 1C, 08 00 00 <ECC of 08 00 00>, then 2 junk bytes -> two non-EoTp pkt_end, a third for EoTp, junk ignored, IDLE after din_valid falls.
REQ-040 Long packet: DT 0x39, wc=9, correct ECC, payload ASCII "123456789", checksum 91 6F -> 9 pl_valid bytes 0x31..0x39 in order, pkt_end with crc_err=0.
REQ-041 The same long packet with checksum 90 6F -> crc_err=1.
REQ-042 ECC fault: burst 05 11 00 37 with ECC_CHECK=1 -> hdr_valid with ecc_err=1, then no further outputs until din_valid falls.
REQ-043 Truncation and reset: long packet wc=16 with din_valid dropped after 5 payload bytes -> 5 pl_valid then trunc with no pkt_end; repeat with rst asserted after 5 payload bytes instead -> all outputs 0 and no trunc.

Source files
------------

// File: rtl/mipi_packet_decoder.sv
// MIPI CSI-2/DSI packet decoder: parses the 4-byte header, checks the ECC, streams the
// long-packet payload and checks the CRC-16 trailer for each packet in an HS burst.
module mipi_packet_decoder #(
  parameter bit ECC_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        hdr_valid,
  output logic [1:0]  vc,
  output logic [5:0]  dt,
  output logic [15:0] wc,
  output logic        is_long,
  output logic        ecc_err,
  output logic [7:0]  pl_data,
  output logic        pl_valid,
  output logic        pkt_end,
  output logic        crc_err,
  output logic        trunc
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_CRC, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  di_q, di_d, wcl_q, wcl_d, wch_q, wch_d, crc_lo_q, crc_lo_d;
  logic [15:0] cnt_q, cnt_d, crc_q, crc_d;
  logic        hdr_valid_q, hdr_valid_d, is_long_q, is_long_d, ecc_err_q, ecc_err_d;
  logic [1:0]  vc_q, vc_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d;
  logic [7:0]  pl_data_q, pl_data_d;
  logic        pl_valid_q, pl_valid_d, pkt_end_q, pkt_end_d, crc_err_q, crc_err_d;
  logic        trunc_q, trunc_d;

  // DSI Hamming parity over D[23:0] = {WC_H, WC_L, DI}
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    return r;
  endfunction

  logic        ecc_bad, long_c;
  logic [15:0] hdr_wc;

  assign hdr_wc  = {wch_q, wcl_q};
  assign ecc_bad = (din[5:0] != ecc6({wch_q, wcl_q, di_q}));
  always_comb begin
    case (di_q[3:0])
      4'h9, 4'hC, 4'hD, 4'hE: long_c = 1'b1;
      default:                long_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      di_q        <= '0;
      wcl_q       <= '0;
      wch_q       <= '0;
      crc_lo_q    <= '0;
      cnt_q       <= '0;
      crc_q       <= '0;
      hdr_valid_q <= 1'b0;
      vc_q        <= '0;
      dt_q        <= '0;
      wc_q        <= '0;
      is_long_q   <= 1'b0;
      ecc_err_q   <= 1'b0;
      pl_data_q   <= '0;
      pl_valid_q  <= 1'b0;
      pkt_end_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      di_q        <= di_d;
      wcl_q       <= wcl_d;
      wch_q       <= wch_d;
      crc_lo_q    <= crc_lo_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      hdr_valid_q <= hdr_valid_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      is_long_q   <= is_long_d;
      ecc_err_q   <= ecc_err_d;
      pl_data_q   <= pl_data_d;
      pl_valid_q  <= pl_valid_d;
      pkt_end_q   <= pkt_end_d;
      crc_err_q   <= crc_err_d;
      trunc_q     <= trunc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    di_d        = di_q;
    wcl_d       = wcl_q;
    wch_d       = wch_q;
    crc_lo_d    = crc_lo_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    is_long_d   = is_long_q;
    ecc_err_d   = ecc_err_q;
    pl_data_d   = pl_data_q;
    crc_err_d   = crc_err_q;
    hdr_valid_d = 1'b0;
    pl_valid_d  = 1'b0;
    pkt_end_d   = 1'b0;
    trunc_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (din_valid) begin
          di_d    = din;
          idx_d   = 2'd1;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (!din_valid) begin
          // a drop at index 0 is just the gap between packets
          trunc_d = (idx_q != 2'd0);
          state_d = S_IDLE;
        end else begin
          case (idx_q)
            2'd0: begin di_d  = din; idx_d = 2'd1; end
            2'd1: begin wcl_d = din; idx_d = 2'd2; end
            2'd2: begin wch_d = din; idx_d = 2'd3; end
            default: begin
              hdr_valid_d = 1'b1;
              vc_d        = di_q[7:6];
              dt_d        = di_q[5:0];
              wc_d        = hdr_wc;
              is_long_d   = long_c;
              ecc_err_d   = ecc_bad;
              idx_d       = 2'd0;
              cnt_d       = hdr_wc;
              crc_d       = 16'hFFFF;
              if (ecc_bad && ECC_CHECK) begin
                state_d = S_DRAIN;
              end else if (!long_c) begin
                pkt_end_d = 1'b1;
                crc_err_d = 1'b0;
                state_d   = (di_q[5:0] == 6'h08) ? S_DRAIN : S_HDR;
              end else begin
                state_d = (hdr_wc == 16'd0) ? S_CRC : S_PAYLOAD;
              end
            end
          endcase
        end
      end
      S_PAYLOAD: begin
        if (!din_valid) begin
          trunc_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          pl_data_d  = din;
          pl_valid_d = 1'b1;
          crc_d      = crc16_byte(crc_q, din);
          cnt_d      = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = S_CRC;
        end
      end
      S_CRC: begin
        if (!din_valid) begin
          trunc_d = 1'b1;
          state_d = S_IDLE;
        end else if (idx_q == 2'd0) begin
          crc_lo_d = din;
          idx_d    = 2'd1;
        end else begin
          pkt_end_d = 1'b1;
          crc_err_d = ({din, crc_lo_q} != crc_q);
          idx_d     = 2'd0;
          state_d   = S_HDR;
        end
      end
      S_DRAIN: begin
        if (!din_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hdr_valid = hdr_valid_q;
  assign vc        = vc_q;
  assign dt        = dt_q;
  assign wc        = wc_q;
  assign is_long   = is_long_q;
  assign ecc_err   = ecc_err_q;
  assign pl_data   = pl_data_q;
  assign pl_valid  = pl_valid_q;
  assign pkt_end   = pkt_end_q;
  assign crc_err   = crc_err_q;
  assign trunc     = trunc_q;

endmodule

// File: tb/tb_mipi_packet_decoder.sv
// Directed bench for mipi_packet_decoder; expected events are queued as bytes are driven
// and matched against DUT pulses one cycle later.
module tb_mipi_packet_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic        hdr_valid, is_long, ecc_err, pl_valid, pkt_end, crc_err, trunc;
  logic [1:0]  vc;
  logic [5:0]  dt;
  logic [15:0] wc;
  logic [7:0]  pl_data;

  mipi_packet_decoder #(.ECC_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .hdr_valid(hdr_valid), .vc(vc), .dt(dt), .wc(wc), .is_long(is_long),
    .ecc_err(ecc_err), .pl_data(pl_data), .pl_valid(pl_valid),
    .pkt_end(pkt_end), .crc_err(crc_err), .trunc(trunc)
  );

  always #5 clk = ~clk;

  localparam int K_NONE = -1, K_HDR = 0, K_PL = 1, K_END = 2, K_TRUNC = 3;
  typedef struct { int kind; logic [63:0] a; } ev_t;
  ev_t sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [63:0] a);
    ev_t e;
    e.kind = k;
    e.a    = a;
    sb.push_back(e);
  endtask

  function automatic logic [63:0] hw(input logic e, input logic l, input logic [1:0] v,
                                     input logic [5:0] d, input logic [15:0] w);
    return {38'b0, e, l, v, d, w};
  endfunction

  task automatic pop_check(input int k, input logic [63:0] obs, input string tag);
    int  ek;
    ev_t e;
    ek = (sb.size() != 0) ? sb[0].kind : K_NONE;
    chk({tag, "_pulse"}, 64'(k), 64'(ek));
    if (ek == k) begin
      e = sb.pop_front();
      chk({tag, "_data"}, obs, e.a);
    end
  endtask

  task automatic check_outputs();
    if (hdr_valid) pop_check(K_HDR, {38'b0, ecc_err, is_long, vc, dt, wc}, "hdr");
    if (pl_valid)  pop_check(K_PL, {56'b0, pl_data}, "payload");
    if (pkt_end)   pop_check(K_END, {63'b0, crc_err}, "pkt_end");
    if (trunc)     pop_check(K_TRUNC, 64'd0, "trunc");
  endtask

  task automatic cycle(input logic [7:0] d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0);
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {25'b0, hdr_valid, vc, dt, wc, is_long, ecc_err, pl_data, pl_valid,
              pkt_end, crc_err, trunc}, 64'd0);
  endtask

  // Short packet 05 11 00 36 within an already-open burst
  task automatic short_05_11();
    cycle(8'h05, 1'b1); cycle(8'h11, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b0, 2'd0, 6'h05, 16'h0011));
    push(K_END, 64'd0);
    cycle(8'h36, 1'b1);
  endtask

  task automatic long_123(input logic [7:0] c0, input logic [7:0] c1, input logic bad);
    cycle(8'h39, 1'b1); cycle(8'h09, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b1, 2'd0, 6'h39, 16'd9));
    cycle(8'h30, 1'b1);
    for (int i = 0; i < 9; i++) begin
      push(K_PL, 64'(8'h31 + i));
      cycle(8'(8'h31 + i), 1'b1);
    end
    cycle(c0, 1'b1);
    push(K_END, {63'b0, bad});
    cycle(c1, 1'b1);
  endtask

  task automatic long16_5();
    cycle(8'h39, 1'b1); cycle(8'h10, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b1, 2'd0, 6'h39, 16'h0010));
    cycle(8'h29, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(K_PL, 64'(8'hA0 + i));
      cycle(8'(8'hA0 + i), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1; din = 8'h00; din_valid = 1'b1;
    cycle(8'h05, 1'b1);
    cycle(8'h00, 1'b0);
    all_zero("reset_state");
    rst = 1'b0;
    idle(2);

    // single short packet
    short_05_11();
    idle(2);
    chk("short_missed", 64'(sb.size()), 64'd0);

    // two shorts then EoTp, then junk that must be ignored
    short_05_11();
    cycle(8'h05, 1'b1); cycle(8'h29, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b0, 2'd0, 6'h05, 16'h0029));
    push(K_END, 64'd0);
    cycle(8'h1C, 1'b1);
    cycle(8'h08, 1'b1); cycle(8'h00, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b0, 2'd0, 6'h08, 16'h0000));
    push(K_END, 64'd0);
    cycle(8'h0E, 1'b1);
    cycle(8'hAA, 1'b1); cycle(8'h55, 1'b1);
    idle(2);
    chk("eotp_missed", 64'(sb.size()), 64'd0);

    // long packet, good and bad checksum
    long_123(8'h91, 8'h6F, 1'b0);
    idle(2);
    chk("long_good_missed", 64'(sb.size()), 64'd0);
    long_123(8'h90, 8'h6F, 1'b1);
    idle(2);
    chk("long_bad_missed", 64'(sb.size()), 64'd0);

    // wc=0 long packet (checksum FFFF) followed by a short in the same burst
    cycle(8'h39, 1'b1); cycle(8'h00, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b1, 2'd0, 6'h39, 16'h0000));
    cycle(8'h0F, 1'b1);
    cycle(8'hFF, 1'b1);
    push(K_END, 64'd0);
    cycle(8'hFF, 1'b1);
    short_05_11();
    idle(2);
    chk("wc0_missed", 64'(sb.size()), 64'd0);

    // vc=2 with ECC bits 7:6 set, which must be ignored
    cycle(8'h85, 1'b1); cycle(8'h11, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b0, 1'b0, 2'd2, 6'h05, 16'h0011));
    push(K_END, 64'd0);
    cycle(8'hEF, 1'b1);
    idle(1);
    chk("vc_missed", 64'(sb.size()), 64'd0);

    // ECC fault drains the rest of the burst, then recovers
    cycle(8'h05, 1'b1); cycle(8'h11, 1'b1); cycle(8'h00, 1'b1);
    push(K_HDR, hw(1'b1, 1'b0, 2'd0, 6'h05, 16'h0011));
    cycle(8'h37, 1'b1);
    cycle(8'h05, 1'b1); cycle(8'h11, 1'b1); cycle(8'h00, 1'b1); cycle(8'h36, 1'b1);
    idle(2);
    short_05_11();
    idle(2);
    chk("ecc_missed", 64'(sb.size()), 64'd0);

    // truncation inside payload and inside header
    long16_5();
    push(K_TRUNC, 64'd0);
    idle(3);
    chk("trunc_pl_missed", 64'(sb.size()), 64'd0);
    cycle(8'h05, 1'b1); cycle(8'h11, 1'b1);
    push(K_TRUNC, 64'd0);
    idle(3);
    chk("trunc_hdr_missed", 64'(sb.size()), 64'd0);

    // reset mid-payload: everything cleared, no trunc/pkt_end afterwards
    long16_5();
    rst = 1'b1;
    cycle(8'hA5, 1'b1);
    all_zero("reset_midpkt");
    rst = 1'b0;
    idle(3);
    short_05_11();
    idle(2);
    chk("reset_missed", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
